regfile_multiport: RTL

Parametrised general-purpose register file that supersedes the single-write, two-read register file in the MIPS datapath. It adds configurable width, depth and read-port count, a second write port for pipelined writeback, a hardwired-zero register, and a per-register busy scoreboard that flags reads of registers with an outstanding producer. It sits between decode (read addresses, reservations) and writeback (write ports).

---
 rtl/regfile_multiport.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_READ combinational reads, two write ports (B wins on
// collision), optional hardwired-zero r0 and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_multiport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                           Clock,
    input  logic                           Reset_L,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    output logic [NUM_READ-1:0]            ReadBusy,
    input  logic                           RegWriteA,
    input  logic                           RegWriteB,
    input  logic [ADDR_WIDTH-1:0]          WriteRegA,
    input  logic [ADDR_WIDTH-1:0]          WriteRegB,
    input  logic [DATA_WIDTH-1:0]          WriteDataA,
    input  logic [DATA_WIDTH-1:0]          WriteDataB,
    input  logic                           ReserveEn,
    input  logic [ADDR_WIDTH-1:0]          ReserveReg
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZeroAddr = '0;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_d [0:DEPTH-1];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic wr_a_en;
    logic wr_b_en;
    logic rsv_en;

    // Register 0 is made inert up front so nothing downstream needs to special-case it.
    assign wr_a_en = RegWriteA && !((ZERO_REG != 0) && (WriteRegA == ZeroAddr));
    assign wr_b_en = RegWriteB && !((ZERO_REG != 0) && (WriteRegB == ZeroAddr));
    assign rsv_en  = ReserveEn && !((ZERO_REG != 0) && (ReserveReg == ZeroAddr));

    // Order matters: B overrides A, and a new reservation overrides a completing write.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_a_en) begin
            mem_d[WriteRegA]  = WriteDataA;
            busy_d[WriteRegA] = 1'b0;
        end
        if (wr_b_en) begin
            mem_d[WriteRegB]  = WriteDataB;
            busy_d[WriteRegB] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[ReserveReg] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_zero;
        logic [DATA_WIDTH-1:0] data;

        assign addr    = ReadReg[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (addr == ZeroAddr);

        always_comb begin
            data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed in reset so reads stay at zero while held.
            if (Reset_L) begin
                if (wr_a_en && (WriteRegA == addr)) data = WriteDataA;
                if (wr_b_en && (WriteRegB == addr)) data = WriteDataB;
            end
`endif
            if (is_zero) data = '0;
        end

        assign ReadData[i*DATA_WIDTH +: DATA_WIDTH] = data;
        assign ReadBusy[i] = busy_q[addr] && !is_zero;
    end

endmodule
